// File: rtl/grid_fetch_requester.sv
// ============================================================================
// Module      : grid_fetch_requester
// Description : DDA-side initiator for the grid map lookup port. Accepts one
//               (map_x, map_y) cell fetch at a time, forms the row-major
//               address map_y*N + map_x, and holds dda_req_out until the grid
//               map answers with dda_valid_in. A request that gets no answer
//               within TIMEOUT cycles is dropped and re-issued, up to
//               MAX_RETRY extra attempts. After that the fetch completes with
//               fetch_err_out set.
//
//               Optional feature macro: GRID_FETCH_OOB_EN
//                 When defined, coordinates >= N are answered locally with
//                 OOB_VALUE one cycle after accept. No grid request is made.
//                 When undefined, there is no range check and the truncated
//                 address is requested as normal.
//
// Ports       : pixel_clk_in    - sole clock
//               rst_in          - asynchronous, active-high reset
//               fetch_valid_in  - upstream fetch request valid
//               fetch_ready_out - fetch can be accepted (idle)
//               map_x_in/map_y_in - cell column/row to fetch
//               fetch_done_out  - one-cycle pulse, data/err valid
//               fetch_data_out  - fetched cell value, held between pulses
//               fetch_err_out   - all attempts timed out (data forced to 0)
//               dda_req_out     - registered request to the grid map
//               dda_address_out - registered grid address
//               dda_valid_in    - one-cycle response pulse from the grid map
//               grid_data_in    - cell value, valid with dda_valid_in
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_fetch_requester #(
  parameter int N         = 24,
  parameter int COORD_W   = 5,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 3,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 3,
  parameter int OOB_VALUE = 1
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic               fetch_valid_in,
  output logic               fetch_ready_out,
  input  logic [COORD_W-1:0] map_x_in,
  input  logic [COORD_W-1:0] map_y_in,
  output logic               fetch_done_out,
  output logic [DATA_W-1:0]  fetch_data_out,
  output logic               fetch_err_out,
  output logic               dda_req_out,
  output logic [ADDR_W-1:0]  dda_address_out,
  input  logic               dda_valid_in,
  input  logic [DATA_W-1:0]  grid_data_in
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int RCNT_W = $clog2(MAX_RETRY + 1);
  // Wide enough to hold map_y*N + map_x before truncation to ADDR_W.
  localparam int FULL_W = (2 * COORD_W + 1 > ADDR_W) ? 2 * COORD_W + 1 : ADDR_W;

  localparam logic [FULL_W-1:0]  c_n_full  = FULL_W'(N);
  localparam logic [COORD_W:0]   c_n_coord = (COORD_W + 1)'(N);
  localparam logic [DATA_W-1:0]  c_oob_val = DATA_W'(OOB_VALUE);

`ifdef GRID_FETCH_OOB_EN
  localparam logic c_oob_en = 1'b1;
`else
  localparam logic c_oob_en = 1'b0;
`endif

  logic [1:0]        r_state;
  logic [TCNT_W-1:0] r_tcnt;
  logic [RCNT_W-1:0] r_retries;
  logic              r_pending;     // a retry attempt follows the current GAP
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_done;
  logic [DATA_W-1:0] r_data;
  logic              r_err;

  logic [ADDR_W-1:0] w_addr;
  logic              w_oob;
  logic              w_timeout;
  logic              w_last_try;

  assign w_addr = ADDR_W'(FULL_W'(map_y_in) * c_n_full + FULL_W'(map_x_in));
  assign w_oob  = ({1'b0, map_x_in} >= c_n_coord) || ({1'b0, map_y_in} >= c_n_coord);

  // The counter holds the number of REQ cycles already spent, so the
  // TIMEOUT-th REQ cycle is the one where it equals TIMEOUT-1.
  assign w_timeout  = (r_tcnt == TCNT_W'(TIMEOUT - 1));
  assign w_last_try = (r_retries == RCNT_W'(MAX_RETRY));

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_retries <= '0;
      r_pending <= 1'b0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_done    <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fetch_valid_in) begin
            r_tcnt    <= '0;
            r_retries <= '0;
            r_pending <= 1'b0;
            if (c_oob_en && w_oob) begin
              r_done <= 1'b1;
              r_data <= c_oob_val;
              r_err  <= 1'b0;
            end else begin
              r_addr  <= w_addr;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // A response in the timeout cycle still counts, so valid is checked first.
          if (dda_valid_in) begin
            r_data  <= grid_data_in;
            r_err   <= 1'b0;
            r_done  <= 1'b1;
            r_req   <= 1'b0;
            r_tcnt  <= '0;
            r_state <= S_GAP;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_tcnt  <= '0;
            r_state <= S_GAP;
            if (w_last_try) begin
              r_done <= 1'b1;
              r_data <= '0;
              r_err  <= 1'b1;
            end else begin
              r_retries <= r_retries + RCNT_W'(1);
              r_pending <= 1'b1;
            end
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end

        S_GAP: begin
          // The grid map only sees rising edges of dda_req_out. Each attempt
          // therefore starts after exactly one low cycle.
          if (r_pending) begin
            r_pending <= 1'b0;
            r_req     <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fetch_ready_out = (r_state == S_IDLE);
  assign fetch_done_out  = r_done;
  assign fetch_data_out  = r_data;
  assign fetch_err_out   = r_err;
  assign dda_req_out     = r_req;
  assign dda_address_out = r_addr;

endmodule

`default_nettype wire
